dmem_responder: RTL

Data-memory responder that serves load/store requests issued by the processor core's memory stage over a valid/ready request channel and a valid/ready response channel. It holds a word-organised RAM, performs byte/half/word accesses with byte-lane steering, sign/zero extension and configurable wait states, and flags misaligned or out-of-range accesses. It is the memory-side end of the core's data-access interface and replaces a zero-latency array once the core moves to a handshaked memory port.

---
 rtl/dmem_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM serving core load/store requests
// over a valid/ready request channel and a valid/ready response channel.
// Byte, half and word accesses use byte-lane steering. Loads are sign- or
// zero-extended. WAIT_STATES extra cycles are inserted before each response.
// Misaligned, illegal-size and out-of-range requests get an error response.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles between acceptance and response (0..15)
// Ports:
//   clk           clock; all state updates on the rising edge
//   mem_reset     asynchronous active-low reset
//   req_valid     request present
//   req_ready     responder can accept a request (registered)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     response present (registered)
//   rsp_ready     core accepts the response
//   rsp_rdata     extended load data; 0 for stores and errors (registered)
//   rsp_err       access rejected (registered)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        mem_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  logic        l_we;
  logic [1:0]  l_size;
  logic        l_unsigned;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // Operand view: live request inputs while idle (acceptance cycle, also
  // used for the zero-wait access), latched copy while waiting.
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic          op_err;
  logic          do_access;

  always_comb begin
    if (state == ST_IDLE) begin
      op_we       = req_we;
      op_size     = req_size;
      op_unsigned = req_unsigned;
      op_addr     = req_addr;
      op_wdata    = req_wdata;
    end else begin
      op_we       = l_we;
      op_size     = l_size;
      op_unsigned = l_unsigned;
      op_addr     = l_addr;
      op_wdata    = l_wdata;
    end
  end

  always_comb begin
    idx  = op_addr[AW+1:2];
    lane = op_addr[1:0];

    op_err = (op_size == 2'b11)
           || ((op_size == 2'b01) && op_addr[0])
           || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
           || (op_addr[31:AW+2] != '0);

    be   = 4'b0000;
    wrep = op_wdata;
    case (op_size)
      2'b00: begin
        be   = 4'b0001 << lane;
        wrep = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << lane;
        wrep = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        be   = 4'b1111;
        wrep = op_wdata;
      end
      default: begin
        be   = 4'b0000;
        wrep = op_wdata;
      end
    endcase

    // Legal words always have lane 0, so the shifted word is the word itself.
    shifted = mem[idx] >> {lane, 3'b000};
    case (op_size)
      2'b00:   load_val = op_unsigned ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = op_unsigned ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase

    do_access = ((state == ST_IDLE) && req_valid && !op_err && (WAIT_STATES == 0))
             || ((state == ST_WAIT) && (wait_cnt == 4'd0));
  end

  // RAM is never reset; the access strobe depends on the reset-cleared
  // state, so an asserted reset aborts any pending store.
  always_ff @(posedge clk) begin
    if (do_access && op_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge mem_reset) begin
    if (!mem_reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      l_we       <= 1'b0;
      l_size     <= '0;
      l_unsigned <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            l_we       <= req_we;
            l_size     <= req_size;
            l_unsigned <= req_unsigned;
            l_addr     <= req_addr;
            l_wdata    <= req_wdata;
            req_ready  <= 1'b0;
            if (op_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (WAIT_STATES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= op_we ? '0 : load_val;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WS_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= op_we ? '0 : load_val;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
